// File: rtl/bcd2bin_seq.sv
// Sequential reverse double-dabble: packed BCD in, unsigned binary out.
// One shift-and-correct iteration per clock, start/ready handshake, done pulse.
module bcd2bin_seq #(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic                  ready,
  output logic                  busy,
  output logic                  done,
  output logic [BIN_W-1:0]      bin_out,
  output logic                  err
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int SR_W  = BCD_W + BIN_W;
  localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t              state_r;
  state_t              state_next_s;
  logic [SR_W-1:0]     sr_r;
  logic [SR_W-1:0]     corrected_s;
  logic [CNT_W-1:0]    cnt_r;
  logic                inv_r;
  logic                ready_r;
  logic                busy_r;
  logic                done_r;
  logic [BIN_W-1:0]    bin_out_r;
  logic                err_r;

  // Any BCD digit above 9 marks the whole word as invalid.
  function automatic logic any_invalid(input logic [BCD_W-1:0] bcd);
    logic bad;
    bad = 1'b0;
    for (int d = 0; d < DIGITS; d++) begin
      if (bcd[4*d +: 4] > 4'd9) begin
        bad = 1'b1;
      end else begin
        bad = bad;
      end
    end
    return bad;
  endfunction

  // Digits that reach 8 or more after the right shift drop back by 3.
  function automatic logic [SR_W-1:0] correct_digits(input logic [SR_W-1:0] word);
    logic [SR_W-1:0] w;
    logic [3:0]      digit;
    w = word;
    for (int d = 0; d < DIGITS; d++) begin
      digit = w[BIN_W + 4*d +: 4];
      if (digit >= 4'd8) begin
        w[BIN_W + 4*d +: 4] = digit - 4'd3;
      end else begin
        w[BIN_W + 4*d +: 4] = digit;
      end
    end
    return w;
  endfunction

  // Shift right with zero fill, then correct every digit of the shifted word.
  always_comb begin
    corrected_s = correct_digits({1'b0, sr_r[SR_W-1:1]});
  end

  // Next-state decode.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_next_s = CONVERT;
        end else begin
          state_next_s = IDLE;
        end
      end
      CONVERT: begin
        if (cnt_r == LAST_CNT) begin
          state_next_s = DONE;
        end else begin
          state_next_s = CONVERT;
        end
      end
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // State, datapath and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      sr_r      <= {SR_W{1'b0}};
      cnt_r     <= {CNT_W{1'b0}};
      inv_r     <= 1'b0;
      ready_r   <= 1'b1;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      bin_out_r <= {BIN_W{1'b0}};
      err_r     <= 1'b0;
    end else begin
      state_r <= state_next_s;
      ready_r <= (state_next_s == IDLE);
      busy_r  <= (state_next_s != IDLE);
      done_r  <= (state_next_s == DONE);
      case (state_r)
        IDLE: begin
          if (start) begin
            sr_r  <= {bcd_in, {BIN_W{1'b0}}};
            cnt_r <= {CNT_W{1'b0}};
            inv_r <= any_invalid(bcd_in);
          end else begin
            sr_r  <= sr_r;
          end
        end
        CONVERT: begin
          sr_r <= corrected_s;
          if (cnt_r == LAST_CNT) begin
            cnt_r     <= {CNT_W{1'b0}};
            bin_out_r <= inv_r ? {BIN_W{1'b0}} : corrected_s[BIN_W-1:0];
            err_r     <= inv_r;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        default: begin
          sr_r <= sr_r;
        end
      endcase
    end
  end

  assign ready   = ready_r;
  assign busy    = busy_r;
  assign done    = done_r;
  assign bin_out = bin_out_r;
  assign err     = err_r;

endmodule
